// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : Fetches 16-bit instructions as two byte reads through the ARF PC
//            and hands them to the decoder over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic        PcLoad,
    input  logic [15:0] PcLoadValue,
    input  logic [15:0] ARF_OutD,
    output logic [15:0] ARF_I,
    output logic [1:0]  ARF_OutDSel,
    output logic [2:0]  ARF_RegSel,
    output logic [1:0]  ARF_FunSel,
    output logic        Mem_Req,
    output logic [15:0] Mem_Addr,
    input  logic        Mem_Ack,
    input  logic [7:0]  Mem_Data,
    output logic [15:0] IR,
    output logic        IR_Valid,
    input  logic        IR_Ready,
    output logic        Busy,
    output logic        Err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        VALID = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam logic [7:0] c_ackTimeout = 8'(ACK_TIMEOUT);

    state_t      r_state;
    state_t      w_nextState;
    logic [7:0]  r_ackCnt;
    logic [7:0]  w_ackCntNext;
    logic [7:0]  w_ackCntInc;
    logic [15:0] r_ir;
    logic        w_capLo;
    logic        w_capHi;
    logic        w_memReq;
    logic [2:0]  w_regSel;
    logic [1:0]  w_funSel;
    logic [15:0] w_arfI;

    assign w_ackCntInc = r_ackCnt + 8'd1;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state  <= IDLE;
            r_ackCnt <= 8'd0;
            r_ir     <= 16'h0000;
        end else begin
            r_state  <= w_nextState;
            r_ackCnt <= w_ackCntNext;
            if (w_capLo) r_ir[7:0]  <= Mem_Data;
            if (w_capHi) r_ir[15:8] <= Mem_Data;
        end
    end

    always_comb begin
        w_nextState  = r_state;
        w_ackCntNext = r_ackCnt;
        w_capLo      = 1'b0;
        w_capHi      = 1'b0;
        w_memReq     = 1'b0;
        w_regSel     = 3'b000;
        w_funSel     = 2'b00;
        w_arfI       = 16'h0000;
        case (r_state)
            IDLE: begin
                if (PcLoad) begin
                    w_arfI   = PcLoadValue;
                    w_regSel = 3'b100;
                    w_funSel = 2'b10;
                end else if (Start) begin
                    w_nextState  = RD_LO;
                    w_ackCntNext = 8'd0;
                end
            end
            RD_LO, RD_HI: begin
                w_memReq = 1'b1;
                if (Mem_Ack) begin
                    // PC advances on the same edge the byte is captured
                    w_capLo      = (r_state == RD_LO);
                    w_capHi      = (r_state == RD_HI);
                    w_regSel     = 3'b100;
                    w_funSel     = 2'b01;
                    w_ackCntNext = 8'd0;
                    w_nextState  = (r_state == RD_LO) ? RD_HI : VALID;
                end else if (w_ackCntInc == c_ackTimeout) begin
                    w_nextState = ERR;
                end else begin
                    w_ackCntNext = w_ackCntInc;
                end
            end
            VALID: begin
                if (IR_Ready) begin
                    if (Start) begin
                        w_nextState  = RD_LO;
                        w_ackCntNext = 8'd0;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
            end
            ERR: begin
                w_nextState = ERR;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // ARF writes are suppressed while Reset is asserted so no write lands on the reset edge
    assign ARF_OutDSel = 2'b00;
    assign ARF_RegSel  = Reset ? w_regSel : 3'b000;
    assign ARF_FunSel  = Reset ? w_funSel : 2'b00;
    assign ARF_I       = Reset ? w_arfI   : 16'h0000;
    assign Mem_Req     = w_memReq;
    assign Mem_Addr    = ARF_OutD;
    assign IR          = r_ir;
    assign IR_Valid    = (r_state == VALID);
    assign Busy        = (r_state != IDLE);
    assign Err         = (r_state == ERR);

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// Bench for fetch_sequencer: models the ARF PC and byte memory, and checks the DUT every cycle against a transaction-level model.
module tb_fetch_sequencer;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        Reset, Start, PcLoad, IR_Ready, Mem_Ack, Mem_Req, IR_Valid, Busy, Err;
    logic [15:0] PcLoadValue, ARF_OutD, ARF_I, Mem_Addr, IR;
    logic [1:0]  ARF_OutDSel, ARF_FunSel;
    logic [2:0]  ARF_RegSel;
    logic [7:0]  Mem_Data;

    fetch_sequencer #(.ACK_TIMEOUT(TIMEOUT)) dut (
        .Clock(clk), .Reset(Reset), .Start(Start), .PcLoad(PcLoad),
        .PcLoadValue(PcLoadValue), .ARF_OutD(ARF_OutD), .ARF_I(ARF_I),
        .ARF_OutDSel(ARF_OutDSel), .ARF_RegSel(ARF_RegSel), .ARF_FunSel(ARF_FunSel),
        .Mem_Req(Mem_Req), .Mem_Addr(Mem_Addr), .Mem_Ack(Mem_Ack), .Mem_Data(Mem_Data),
        .IR(IR), .IR_Valid(IR_Valid), .IR_Ready(IR_Ready), .Busy(Busy), .Err(Err)
    );

    // Environment: PC register of the ARF and a byte memory with programmable wait states
    logic [7:0]  mem [0:65535];
    logic [15:0] pc = 16'h0000;
    int          envWait = 0;
    int          ackDelay;
    logic [15:0] blockAddr;
    logic        forceAck;

    assign ARF_OutD = (ARF_OutDSel == 2'b00) ? pc : 16'hDEAD;
    assign Mem_Data = mem[Mem_Addr];
    assign Mem_Ack  = forceAck || (Mem_Req && (envWait >= ackDelay) && (Mem_Addr != blockAddr));

    always @(posedge clk) begin
        if (ARF_RegSel[2]) begin
            case (ARF_FunSel)
                2'b00: pc <= pc - 16'd1;
                2'b01: pc <= pc + 16'd1;
                2'b10: pc <= ARF_I;
                default: pc <= 16'h0000;
            endcase
        end
        if (Mem_Req && !Mem_Ack) envWait <= envWait + 1;
        else envWait <= 0;
    end

    // Reference model: fetch activity tracked as phase flags plus expected PC
    bit          mFetching = 1'b0, mHi = 1'b0, mHaveInstr = 1'b0, mErr = 1'b0;
    logic [15:0] mIr = 16'h0000;
    logic [15:0] mExpPc = 16'h0000;
    int          mWaited = 0;

    always @(posedge clk) begin
        if (!Reset) begin
            mFetching <= 1'b0; mHi <= 1'b0; mHaveInstr <= 1'b0; mErr <= 1'b0;
            mIr <= 16'h0000; mWaited <= 0;
        end else if (mErr) begin
            mErr <= 1'b1;
        end else if (mFetching) begin
            if (Mem_Ack) begin
                if (mHi) begin
                    mIr[15:8] <= mem[mExpPc];
                    mFetching <= 1'b0;
                    mHaveInstr <= 1'b1;
                end else begin
                    mIr[7:0] <= mem[mExpPc];
                    mHi <= 1'b1;
                end
                mExpPc  <= mExpPc + 16'd1;
                mWaited <= 0;
            end else if (mWaited + 1 == TIMEOUT) begin
                mErr <= 1'b1;
                mFetching <= 1'b0;
            end else begin
                mWaited <= mWaited + 1;
            end
        end else if (mHaveInstr) begin
            if (IR_Ready) begin
                mHaveInstr <= 1'b0;
                if (Start) begin mFetching <= 1'b1; mHi <= 1'b0; mWaited <= 0; end
            end
        end else if (PcLoad) begin
            mExpPc <= PcLoadValue;
        end else if (Start) begin
            mFetching <= 1'b1; mHi <= 1'b0; mWaited <= 0;
        end
    end

    int checks = 0;
    int errors = 0;
    bit chkEn  = 1'b0;

    task chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit expLoad, expInc;
        if (chkEn) begin
            expLoad = Reset && PcLoad && !mFetching && !mHaveInstr && !mErr;
            expInc  = Reset && mFetching && Mem_Ack;
            chk("IR", IR, mIr);
            chk("IR_Valid", IR_Valid, mHaveInstr);
            chk("Busy", Busy, mFetching || mHaveInstr || mErr);
            chk("Err", Err, mErr);
            chk("Mem_Req", Mem_Req, mFetching);
            chk("PC", pc, mExpPc);
            chk("RegSel", ARF_RegSel, (expLoad || expInc) ? 3'b100 : 3'b000);
            chk("FunSel", ARF_FunSel, expLoad ? 2'b10 : (expInc ? 2'b01 : 2'b00));
            chk("OutDSel", ARF_OutDSel, 2'b00);
            if (mFetching) chk("Mem_Addr", Mem_Addr, mExpPc);
            if (expLoad) chk("ARF_I", ARF_I, PcLoadValue);
        end
    end

    task step();
        @(posedge clk);
        #1;
    endtask

    task loadPc(input logic [15:0] v);
        PcLoad = 1'b1;
        PcLoadValue = v;
        step();
        PcLoad = 1'b0;
    endtask

    task doFetch();
        Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    task automatic waitValid(input int maxCyc, output int reqCyc, output bit got);
        reqCyc = 0;
        got = 1'b0;
        for (int i = 0; i < maxCyc; i++) begin
            @(negedge clk);
            if (IR_Valid) begin got = 1'b1; break; end
            if (Mem_Req) reqCyc++;
            step();
        end
    endtask

    int reqCyc;
    bit got;

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[16'h0040] = 8'h34; mem[16'h0041] = 8'h12;
        mem[16'h0042] = 8'h78; mem[16'h0043] = 8'h56;
        mem[16'hFFFF] = 8'hAB; mem[16'h0000] = 8'hCD;
        mem[16'h0001] = 8'hEF; mem[16'h0002] = 8'h99;
        Reset = 1'b0; Start = 1'b0; PcLoad = 1'b0; PcLoadValue = 16'h0000;
        IR_Ready = 1'b0; forceAck = 1'b0; ackDelay = 0; blockAddr = 16'h7777;

        // Reset held for two cycles
        step();
        chkEn = 1'b1;
        step();
        @(negedge clk);
        chk("rst IR", IR, 16'h0000);
        chk("rst IR_Valid", IR_Valid, 1'b0);
        chk("rst Mem_Req", Mem_Req, 1'b0);
        chk("rst RegSel", ARF_RegSel, 3'b000);
        chk("rst ARF_I", ARF_I, 16'h0000);
        chk("rst Busy", Busy, 1'b0);
        chk("rst Err", Err, 1'b0);
        step();
        Reset = 1'b1;

        // PC load in IDLE
        PcLoad = 1'b1; PcLoadValue = 16'h0040;
        @(negedge clk);
        chk("load RegSel", ARF_RegSel, 3'b100);
        chk("load FunSel", ARF_FunSel, 2'b10);
        chk("load ARF_I", ARF_I, 16'h0040);
        step();
        PcLoad = 1'b0;
        @(negedge clk);
        chk("load PC", pc, 16'h0040);
        chk("load RegSel idle", ARF_RegSel, 3'b000);
        step();

        // Zero-wait fetch, two-cycle latency
        IR_Ready = 1'b1;
        doFetch();
        @(negedge clk);
        chk("zw addr lo", Mem_Addr, 16'h0040);
        chk("zw req lo", Mem_Req, 1'b1);
        step();
        @(negedge clk);
        chk("zw addr hi", Mem_Addr, 16'h0041);
        step();
        @(negedge clk);
        chk("zw valid", IR_Valid, 1'b1);
        chk("zw IR", IR, 16'h1234);
        chk("zw PC", pc, 16'h0042);
        step();

        // Wait-state fetch with decoder back-pressure, then back-to-back fetch
        loadPc(16'h0040);
        ackDelay = 3;
        IR_Ready = 1'b0;
        doFetch();
        waitValid(40, reqCyc, got);
        chk("ws valid reached", got, 1'b1);
        chk("ws req cycles", reqCyc, 8);
        for (int k = 0; k < 4; k++) begin
            chk("ws hold IR", IR, 16'h1234);
            chk("ws hold valid", IR_Valid, 1'b1);
            step();
            @(negedge clk);
        end
        step();
        IR_Ready = 1'b1; Start = 1'b1;
        @(negedge clk);
        chk("b2b valid before", IR_Valid, 1'b1);
        step();
        Start = 1'b0;
        @(negedge clk);
        chk("b2b req", Mem_Req, 1'b1);
        chk("b2b addr", Mem_Addr, 16'h0042);
        chk("b2b valid drop", IR_Valid, 1'b0);
        step();
        waitValid(40, reqCyc, got);
        chk("b2b valid reached", got, 1'b1);
        chk("b2b IR", IR, 16'h5678);
        step();

        // PC wrap at FFFF
        ackDelay = 0;
        loadPc(16'hFFFF);
        doFetch();
        waitValid(20, reqCyc, got);
        chk("wrap valid reached", got, 1'b1);
        chk("wrap IR", IR, 16'hCDAB);
        chk("wrap PC", pc, 16'h0001);
        step();

        // Ack outside a read is ignored
        forceAck = 1'b1;
        step();
        step();
        forceAck = 1'b0;
        @(negedge clk);
        chk("stray ack IR", IR, 16'hCDAB);
        chk("stray ack Busy", Busy, 1'b0);
        step();

        // High byte never acknowledged -> timeout
        blockAddr = 16'h0002;
        doFetch();
        reqCyc = 0; got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Err) begin got = 1'b1; break; end
            if (Mem_Req) reqCyc++;
            step();
        end
        chk("to err reached", got, 1'b1);
        chk("to req cycles", reqCyc, 1 + TIMEOUT);
        chk("to busy", Busy, 1'b1);
        chk("to req off", Mem_Req, 1'b0);
        step();
        Start = 1'b1; PcLoad = 1'b1; PcLoadValue = 16'h1111;
        step(); step(); step();
        @(negedge clk);
        chk("err sticky", Err, 1'b1);
        chk("err PC", pc, 16'h0002);
        chk("err RegSel", ARF_RegSel, 3'b000);
        step();
        Start = 1'b0; PcLoad = 1'b0; Reset = 1'b0;
        step();
        @(negedge clk);
        chk("err cleared", Err, 1'b0);
        chk("err busy cleared", Busy, 1'b0);
        step();
        Reset = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
